// File: rtl/ujtag_reg_ctrl_if.sv
// Register-bus handshake between the UJTAG controller (master) and the CSR file (slave).
interface ujtag_reg_ctrl_if;
  logic [6:0]  bus_addr;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_addr, bus_wr, bus_rd, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_addr, bus_wr, bus_rd, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/ujtag_reg_ctrl.sv
// Oversamples the UJTAG user DR signals in the fabric clock and turns each 40-bit
// DR scan {wr, addr[6:0], data[31:0]} into one register-bus read or write.
module ujtag_reg_ctrl #(
  parameter logic [7:0]  IR_CODE     = 8'h10,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              UIREG,
  input  logic                    URSTB,
  input  logic                    UDRCAP,
  input  logic                    UDRSH,
  input  logic                    UDRUPD,
  input  logic                    UDRCK,
  input  logic                    UTDI,
  output logic                    UTDO,
  ujtag_reg_ctrl_if.master        bus,
  output logic                    busy
);

  typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  logic [13:0]                   pin_in;
  logic [SYNC_STAGES-1:0][13:0]  sync_q;
  logic [13:0]                   s;
  logic                          ck_prev_q;

  logic [7:0] s_ir;
  logic       s_urstb, s_cap, s_sh, s_upd, s_ck, s_tdi;
  logic       dr_edge, sel, cap_evt, sh_evt, upd_evt, waiting, to_evt;

  state_e      state_q;
  logic [39:0] sr_q;
  logic [31:0] rd_reg_q;
  logic [15:0] cnt_q;
  logic        tflag_q, oflag_q, utdo_q;
  logic [6:0]  addr_q;
  logic [31:0] wdata_q;
  logic        wr_q, rd_q;

  assign pin_in = {UIREG, URSTB, UDRCAP, UDRSH, UDRUPD, UDRCK, UTDI};
  assign s      = sync_q[SYNC_STAGES-1];

  assign s_ir    = s[13:6];
  assign s_urstb = s[5];
  assign s_cap   = s[4];
  assign s_sh    = s[3];
  assign s_upd   = s[2];
  assign s_ck    = s[1];
  assign s_tdi   = s[0];

  // All qualifiers share the UDRCK pipeline depth, so they line up with dr_edge.
  assign dr_edge = s_ck & ~ck_prev_q;
  assign sel     = (s_ir == IR_CODE) && s_urstb;
  assign cap_evt = dr_edge & sel & s_cap;
  assign sh_evt  = dr_edge & sel & ~s_cap & s_sh;
  assign upd_evt = dr_edge & sel & ~s_cap & ~s_sh & s_upd;
  assign waiting = (state_q != StIdle);
  assign to_evt  = waiting & ~bus.bus_ack & (cnt_q == CntLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      ck_prev_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pin_in};
      ck_prev_q <= s_ck;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sr_q     <= '0;
      rd_reg_q <= '0;
      cnt_q    <= '0;
      tflag_q  <= 1'b0;
      oflag_q  <= 1'b0;
      utdo_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      if (!s_urstb) begin
        sr_q <= '0;
      end else if (cap_evt) begin
        sr_q <= {5'b0, oflag_q, tflag_q, waiting, rd_reg_q};
      end else if (sh_evt) begin
        sr_q <= {s_tdi, sr_q[39:1]};
      end
      utdo_q <= s_urstb ? sr_q[0] : 1'b0;

      // Later assignments win: a flag setting in a capture cycle stays set.
      if (cap_evt) begin
        tflag_q <= 1'b0;
        oflag_q <= 1'b0;
      end
      if (to_evt) tflag_q <= 1'b1;
      if (upd_evt && waiting) oflag_q <= 1'b1;

      case (state_q)
        StIdle: begin
          if (upd_evt) begin
            addr_q  <= sr_q[38:32];
            wdata_q <= sr_q[31:0];
            cnt_q   <= '0;
            wr_q    <= sr_q[39];
            rd_q    <= ~sr_q[39];
            state_q <= sr_q[39] ? StWr : StRd;
          end
        end
        StWr, StRd: begin
          if (bus.bus_ack || to_evt) begin
            if (state_q == StRd && bus.bus_ack) rd_reg_q <= bus.bus_rdata;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign UTDO          = utdo_q;
  assign busy          = waiting;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_wr    = wr_q;
  assign bus.bus_rd    = rd_q;

endmodule
